// File: rtl/exe_pkg.sv
// exe_pkg: shared widths, ALU opcodes and forwarding-select encodings for the execute slice
package exe_pkg;
  localparam int EXE_DW = 32;
  localparam int EXE_RW = 5;
  localparam int EXE_OPW = 4;
  localparam logic [3:0] EXE_ADD = 4'd0;
  localparam logic [3:0] EXE_SUB = 4'd1;
  localparam logic [3:0] EXE_AND = 4'd2;
  localparam logic [3:0] EXE_OR = 4'd3;
  localparam logic [3:0] EXE_NOR = 4'd4;
  localparam logic [3:0] EXE_XOR = 4'd5;
  localparam logic [3:0] EXE_SLA = 4'd6;
  localparam logic [3:0] EXE_SLL = 4'd7;
  localparam logic [3:0] EXE_SRA = 4'd8;
  localparam logic [3:0] EXE_SRL = 4'd9;
  localparam logic [1:0] FW_ID_EX = 2'd0;
  localparam logic [1:0] FW_EX_MEM = 2'd1;
  localparam logic [1:0] FW_WB = 2'd2;
endpackage

// File: rtl/exe_stage_pipeline_alu.sv
// exe_alu: combinational ALU, shifts use b[4:0], undefined opcodes give 0
module exe_alu
  import exe_pkg::*;
#(
  parameter int DW = EXE_DW,
  parameter int OPW = EXE_OPW
) (
  input  logic [OPW-1:0] cmd,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic [DW-1:0]  res
);
  logic [4:0] sh;
  logic [DW-1:0] sra;
  assign sh = b[4:0];
  // kept apart so the ternary chain below cannot strip the signedness of >>>
  assign sra = $signed(a) >>> sh;
  always_comb
    res = cmd == EXE_ADD ? a + b :
          cmd == EXE_SUB ? a - b :
          cmd == EXE_AND ? a & b :
          cmd == EXE_OR  ? a | b :
          cmd == EXE_NOR ? ~(a | b) :
          cmd == EXE_XOR ? a ^ b :
          (cmd == EXE_SLA || cmd == EXE_SLL) ? a << sh :
          cmd == EXE_SRA ? sra :
          cmd == EXE_SRL ? a >> sh : '0;
endmodule

// File: rtl/exe_stage_pipeline.sv
// exe_stage_pipeline: ID/EX register, forwarding muxes + ALU, EX/MEM register.
// FORWARDING_EN enables the forwarding selects; otherwise they are ignored.
module exe_stage_pipeline
  import exe_pkg::*;
#(
  parameter int DW = EXE_DW,
  parameter int RW = EXE_RW,
  parameter int OPW = EXE_OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RW-1:0]  dest_id,
  input  logic [RW-1:0]  src1_id,
  input  logic [RW-1:0]  src2_id,
  input  logic [DW-1:0]  reg2_id,
  input  logic [DW-1:0]  val1_id,
  input  logic [DW-1:0]  val2_id,
  input  logic [DW-1:0]  pc_id,
  input  logic [OPW-1:0] exe_cmd_id,
  input  logic           mem_r_en_id,
  input  logic           mem_w_en_id,
  input  logic           wb_en_id,
  input  logic           br_taken_id,
  input  logic [1:0]     val1_sel,
  input  logic [1:0]     val2_sel,
  input  logic [1:0]     st_val_sel,
  input  logic [DW-1:0]  wb_result,
  output logic [RW-1:0]  src1_exe,
  output logic [RW-1:0]  src2_exe,
  output logic [RW-1:0]  dest_exe,
  output logic           wb_en_exe,
  output logic           mem_r_en_exe,
  output logic           br_taken_exe,
  output logic [DW-1:0]  alu_res_exe,
  output logic [DW-1:0]  alu_res_mem,
  output logic [DW-1:0]  st_val_mem,
  output logic [DW-1:0]  pc_mem,
  output logic [RW-1:0]  dest_mem,
  output logic           wb_en_mem,
  output logic           mem_r_en_mem,
  output logic           mem_w_en_mem
);
  logic [DW-1:0] reg2_exe, val1_exe, val2_exe, pc_exe;
  logic [OPW-1:0] cmd_exe;
  logic mem_w_en_exe;
  logic [1:0] s1, s2, s3;
  logic [DW-1:0] a, b, st_val;
`ifdef FORWARDING_EN
  assign s1 = val1_sel;
  assign s2 = val2_sel;
  assign s3 = st_val_sel;
`else
  logic unused_sel;
  assign unused_sel = ^{val1_sel, val2_sel, st_val_sel};
  assign s1 = FW_ID_EX;
  assign s2 = FW_ID_EX;
  assign s3 = FW_ID_EX;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {dest_exe, src1_exe, src2_exe} <= '0;
      {reg2_exe, val1_exe, val2_exe, pc_exe, cmd_exe} <= '0;
      {mem_r_en_exe, mem_w_en_exe, wb_en_exe, br_taken_exe} <= '0;
    end else begin
      {dest_exe, src1_exe, src2_exe} <= {dest_id, src1_id, src2_id};
      {reg2_exe, val1_exe, val2_exe, pc_exe, cmd_exe} <= {reg2_id, val1_id, val2_id, pc_id, exe_cmd_id};
      {mem_r_en_exe, mem_w_en_exe, wb_en_exe, br_taken_exe} <= {mem_r_en_id, mem_w_en_id, wb_en_id, br_taken_id};
    end
  // select 3 falls back to the ID/EX value like select 0
  always_comb begin
    a = s1 == FW_EX_MEM ? alu_res_mem : s1 == FW_WB ? wb_result : val1_exe;
    b = s2 == FW_EX_MEM ? alu_res_mem : s2 == FW_WB ? wb_result : val2_exe;
    st_val = s3 == FW_EX_MEM ? alu_res_mem : s3 == FW_WB ? wb_result : reg2_exe;
  end
  exe_alu #(.DW(DW), .OPW(OPW)) u_alu (
    .cmd(cmd_exe),
    .a(a),
    .b(b),
    .res(alu_res_exe)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {alu_res_mem, st_val_mem, pc_mem, dest_mem} <= '0;
      {wb_en_mem, mem_r_en_mem, mem_w_en_mem} <= '0;
    end else begin
      {alu_res_mem, st_val_mem, pc_mem, dest_mem} <= {alu_res_exe, st_val, pc_exe, dest_exe};
      {wb_en_mem, mem_r_en_mem, mem_w_en_mem} <= {wb_en_exe, mem_r_en_exe, mem_w_en_exe};
    end
endmodule

// File: tb/tb_exe_stage_pipeline.sv
// tb_exe_stage_pipeline: random and directed stimulus against a transaction-level reference model
module tb_exe_stage_pipeline;
  typedef struct {
    logic [4:0] dest, src1, src2;
    logic [31:0] reg2, val1, val2, pc;
    logic [3:0] cmd;
    logic mr, mw, wb, br;
  } id_t;
  typedef struct {
    logic [31:0] alu, st, pc;
    logic [4:0] dest;
    logic wb, mr, mw;
  } mem_t;
  logic clk = 0, rst = 1;
  logic [4:0] dest_id = 0, src1_id = 0, src2_id = 0;
  logic [31:0] reg2_id = 0, val1_id = 0, val2_id = 0, pc_id = 0, wb_result = 0;
  logic [3:0] exe_cmd_id = 0;
  logic mem_r_en_id = 0, mem_w_en_id = 0, wb_en_id = 0, br_taken_id = 0;
  logic [1:0] val1_sel = 0, val2_sel = 0, st_val_sel = 0;
  logic [4:0] src1_exe, src2_exe, dest_exe, dest_mem;
  logic wb_en_exe, mem_r_en_exe, br_taken_exe, wb_en_mem, mem_r_en_mem, mem_w_en_mem;
  logic [31:0] alu_res_exe, alu_res_mem, st_val_mem, pc_mem;
  int checks = 0, errors = 0;
  id_t ex_m, nop, t;
  mem_t mem_m;
  exe_stage_pipeline dut (
    .clk(clk), .rst(rst), .dest_id(dest_id), .src1_id(src1_id), .src2_id(src2_id),
    .reg2_id(reg2_id), .val1_id(val1_id), .val2_id(val2_id), .pc_id(pc_id),
    .exe_cmd_id(exe_cmd_id), .mem_r_en_id(mem_r_en_id), .mem_w_en_id(mem_w_en_id),
    .wb_en_id(wb_en_id), .br_taken_id(br_taken_id), .val1_sel(val1_sel),
    .val2_sel(val2_sel), .st_val_sel(st_val_sel), .wb_result(wb_result),
    .src1_exe(src1_exe), .src2_exe(src2_exe), .dest_exe(dest_exe), .wb_en_exe(wb_en_exe),
    .mem_r_en_exe(mem_r_en_exe), .br_taken_exe(br_taken_exe), .alu_res_exe(alu_res_exe),
    .alu_res_mem(alu_res_mem), .st_val_mem(st_val_mem), .pc_mem(pc_mem),
    .dest_mem(dest_mem), .wb_en_mem(wb_en_mem), .mem_r_en_mem(mem_r_en_mem),
    .mem_w_en_mem(mem_w_en_mem)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] alu_m(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [31:0] r;
    s = int'(b % 32);
    case (op)
      0: r = a + b;
      1: r = a + ~b + 1;
      2: r = a & b;
      3: r = a | b;
      4: r = ~(a | b);
      5: r = a ^ b;
      6, 7: r = a * (32'd1 << s);
      8: r = a[31] ? ((a >> s) | ~(32'hFFFF_FFFF >> s)) : a >> s;
      9: r = a / (32'd1 << s);
      default: r = 0;
    endcase
    return r;
  endfunction
  function automatic logic [31:0] fw(input logic [1:0] sel, input logic [31:0] v);
`ifdef FORWARDING_EN
    return sel == 1 ? mem_m.alu : sel == 2 ? wb_result : v;
`else
    return sel == 3 ? v : v;
`endif
  endfunction
  function automatic logic [31:0] exp_alu();
    return alu_m(ex_m.cmd, fw(val1_sel, ex_m.val1), fw(val2_sel, ex_m.val2));
  endfunction
  task automatic check_all();
    chk("src1_exe", 32'(src1_exe), 32'(ex_m.src1));
    chk("src2_exe", 32'(src2_exe), 32'(ex_m.src2));
    chk("dest_exe", 32'(dest_exe), 32'(ex_m.dest));
    chk("ctl_exe", 32'({wb_en_exe, mem_r_en_exe, br_taken_exe}), 32'({ex_m.wb, ex_m.mr, ex_m.br}));
    chk("alu_res_exe", alu_res_exe, exp_alu());
    chk("alu_res_mem", alu_res_mem, mem_m.alu);
    chk("st_val_mem", st_val_mem, mem_m.st);
    chk("pc_mem", pc_mem, mem_m.pc);
    chk("dest_mem", 32'(dest_mem), 32'(mem_m.dest));
    chk("ctl_mem", 32'({wb_en_mem, mem_r_en_mem, mem_w_en_mem}), 32'({mem_m.wb, mem_m.mr, mem_m.mw}));
  endtask
  task automatic cyc(input id_t x, input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                     input logic [31:0] wbr, input logic r);
    mem_t nm;
    @(negedge clk);
    rst = r;
    {dest_id, src1_id, src2_id, reg2_id, val1_id, val2_id, pc_id} = {x.dest, x.src1, x.src2, x.reg2, x.val1, x.val2, x.pc};
    {exe_cmd_id, mem_r_en_id, mem_w_en_id, wb_en_id, br_taken_id} = {x.cmd, x.mr, x.mw, x.wb, x.br};
    {val1_sel, val2_sel, st_val_sel, wb_result} = {a1, a2, a3, wbr};
    if (r) begin
      ex_m = nop;
      mem_m = '{default: 0};
    end
    #1 check_all();
    nm.alu = exp_alu();
    nm.st = fw(st_val_sel, ex_m.reg2);
    nm.pc = ex_m.pc;
    nm.dest = ex_m.dest;
    {nm.wb, nm.mr, nm.mw} = {ex_m.wb, ex_m.mr, ex_m.mw};
    mem_m = r ? '{default: 0} : nm;
    ex_m = r ? nop : x;
  endtask
  function automatic id_t rnd();
    id_t x;
    {x.dest, x.src1, x.src2} = 15'($urandom);
    {x.reg2, x.val1, x.val2, x.pc} = {$urandom, $urandom, $urandom, $urandom};
    x.cmd = 4'($urandom);
    {x.mr, x.mw, x.wb, x.br} = 4'($urandom);
    return x;
  endfunction
  function automatic id_t op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    id_t x;
    x = nop;
    x.cmd = c;
    x.val1 = a;
    x.val2 = b;
    return x;
  endfunction
  initial begin
    logic [3:0] ops [10] = '{0, 1, 2, 3, 4, 5, 7, 9, 12, 6};
    logic [31:0] res [10] = '{32'h12, 32'h0C, 32'h03, 32'h0F, 32'hFFFF_FFF0, 32'h0C, 32'h78, 32'h01, 32'h0, 32'h78};
    nop = '{default: 0};
    ex_m = nop;
    mem_m = '{default: 0};
    repeat (2) cyc(nop, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(op(ops[i], 32'h0000_000F, 32'h0000_0003), 0, 0, 0, 0, 0);
      repeat (2) cyc(nop, 0, 0, 0, 0, 0);
      chk("sweep", alu_res_mem, res[i]);
    end
    cyc(op(4'd8, 32'h8000_0000, 32'h0000_0021), 0, 0, 0, 0, 0);
    cyc(op(4'd9, 32'h8000_0000, 32'h0000_0021), 0, 0, 0, 0, 0);
    cyc(nop, 0, 0, 0, 0, 0);
    chk("sra", alu_res_mem, 32'hC000_0000);
    cyc(nop, 0, 0, 0, 0, 0);
    chk("srl", alu_res_mem, 32'h4000_0000);
    cyc(op(4'd0, 5, 7), 0, 0, 0, 0, 0);
    cyc(op(4'd0, 32'h100, 1), 0, 0, 0, 0, 0);
    cyc(nop, 1, 0, 0, 0, 0);
`ifdef FORWARDING_EN
    chk("fwd_ex", alu_res_exe, 32'd13);
`else
    chk("fwd_off", alu_res_exe, 32'h101);
`endif
    t = nop;
    t.mw = 1;
    t.reg2 = 32'h1234;
    cyc(t, 0, 0, 0, 0, 0);
    cyc(nop, 0, 0, 2, 32'hDEAD_BEEF, 0);
    cyc(nop, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
    chk("st_wb", st_val_mem, 32'hDEAD_BEEF);
`else
    chk("st_wb_off", st_val_mem, 32'h1234);
`endif
    chk("mw_mem", 32'(mem_w_en_mem), 1);
    t = nop;
    {t.pc, t.dest, t.wb, t.mr} = {32'h40, 5'd9, 1'b1, 1'b1};
    cyc(t, 0, 0, 0, 0, 0);
    repeat (2) cyc(nop, 0, 0, 0, 0, 0);
    chk("pc_pass", pc_mem, 32'h40);
    chk("dest_pass", 32'(dest_mem), 9);
    chk("ctl_pass", 32'({wb_en_mem, mem_r_en_mem}), 3);
    for (int i = 0; i < 300; i++)
      cyc(rnd(), 2'($urandom), 2'($urandom), 2'($urandom), $urandom, 0);
    t = rnd();
    t.dest = 5'd17;
    cyc(t, 0, 0, 0, 32'h5555, 1);
    chk("rst_alu_mem", alu_res_mem, 0);
    chk("rst_pc_mem", pc_mem, 0);
    chk("rst_dest_exe", 32'(dest_exe), 0);
    cyc(t, 0, 0, 0, 0, 1);
    cyc(t, 0, 0, 0, 0, 0);
    cyc(nop, 0, 0, 0, 0, 0);
    chk("post_rst", 32'(dest_exe), 17);
    for (int i = 0; i < 200; i++)
      cyc(rnd(), 2'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom_range(0, 19) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_stage_pipeline.md
Name: exe_stage_pipeline

Overview:
- Execute slice of the 5-stage pipelined MIPS-like core.
- Contains three parts in order:
  - the ID/EX pipeline register;
  - the execute datapath: forwarding muxes, 4-bit-opcode ALU and store-value mux;
  - the EX/MEM pipeline register.
- Sits between decode (register file, hazard unit) and the data-memory stage.
- Forwarding selects come from an external forwarding unit, which is fed by this block's src/dest outputs.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.
- OPW, 4, ALU opcode width.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: asynchronous, active-high reset.
- dest_id in RW: destination register from decode.
- src1_id in RW: source-1 register address.
- src2_id in RW: source-2 register address (store/branch source when applicable).
- reg2_id in DW: raw register-file read of src2; this is the store value.
- val1_id in DW: ALU operand 1.
- val2_id in DW: ALU operand 2 (register value or sign-extended immediate).
- pc_id in DW: PC of the decoded instruction.
- exe_cmd_id in OPW: ALU opcode.
- mem_r_en_id, mem_w_en_id, wb_en_id, br_taken_id in 1 each: control bits.
- val1_sel, val2_sel, st_val_sel in 2 each: forwarding selects, applied in EX.
- wb_result in DW: write-back-stage result, used as a forwarding source.
- src1_exe, src2_exe, dest_exe out RW: EX-stage addresses, for the forwarding and hazard units.
- wb_en_exe, mem_r_en_exe, br_taken_exe out 1: EX-stage control bits.
- alu_res_exe out DW: combinational ALU result.
- alu_res_mem out DW: registered ALU result.
- st_val_mem out DW: registered store value.
- pc_mem out DW: registered PC.
- dest_mem out RW: registered destination.
- wb_en_mem, mem_r_en_mem, mem_w_en_mem out 1: registered control bits.

Behaviour:
- ID/EX register: on posedge clk, every *_id input is captured into its EX copy.
- EX/MEM register: on posedge clk, captures the following from EX:
  - alu_res_exe;
  - the forwarded store value;
  - pc, dest, wb_en, mem_r_en, mem_w_en.
- Latency: one cycle through each register.
  - An instruction presented at ID in cycle N has its ALU result on alu_res_mem after the edge ending cycle N+1.
- Reset: when rst=1, all registered outputs and internal register state go to 0 immediately.
  - All data, addresses, control bits and PCs are cleared.
  - Holds while rst=1, including mid-stream: in-flight instructions are discarded.
  - With control bits at 0, a reset slot is a NOP.
- Forwarding muxes (combinational; the same encoding is used for val1_sel, val2_sel and st_val_sel):
  - 0 = value held in ID/EX;
  - 1 = alu_res_mem (EX-to-EX forwarding);
  - 2 = wb_result (MEM/WB-to-EX forwarding);
  - 3 = value held in ID/EX.
- ALU opcodes: a = forwarded val1, b = forwarded val2. Results are DW bits and wrap modulo 2^DW; there are no flags.
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 NOR.
  - 5 XOR.
  - 6 SLA: a<<b[4:0].
  - 7 SLL: a<<b[4:0].
  - 8 SRA: arithmetic a>>>b[4:0].
  - 9 SRL: logical a>>b[4:0].
  - 10-15: result 0.
- Shift amounts use only b[4:0]; upper bits of b are ignored.
- No stall or flush inputs: bubbles arrive as zeroed control bits from decode.
- br_taken passes through the EX copy only; it is not carried to MEM.
- Simultaneous events: a select value and the source it chooses are combinational.
  - alu_res_mem and wb_result are sampled in the same cycle they are selected.
  - No extra delay.

Optional Feature:
- Macro FORWARDING_EN.
- When defined: val1_sel, val2_sel and st_val_sel act as specified above.
- When undefined:
  - all three selects are internally forced to 0;
  - select ports remain present but are ignored;
  - the external hazard unit must stall for every RAW dependency.

Decomposition:
- Shared package exe_pkg holds:
  - ALU opcode localparams (EXE_ADD..EXE_SRL);
  - forwarding-select encodings (FW_ID_EX=0, FW_EX_MEM=1, FW_WB=2);
  - DW/RW/OPW defaults.
- One natural sub-module: exe_alu (pure combinational ALU, opcode plus two operands in, result out).
- Both pipeline registers and the muxes stay in the top module.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 mid-stream with nonzero inputs.
  - Required: all registered outputs are 0 immediately; after release, the first capture appears one edge later.
- ALU sweep, no forwarding:
  - Inputs: val1=0x0000_000F, val2=0x0000_0003, selects=0.
  - Required alu_res_mem per opcode: ADD 0x12, SUB 0x0C, AND 0x03, OR 0x0F, NOR 0xFFFF_FFF0, XOR 0x0C, SLL 0x78, SRL 0x01.
  - Opcode 12 gives 0.
- Arithmetic shift:
  - Inputs: val1=0x8000_0000, val2=0x0000_0021.
  - SRA → 0xC000_0000 (shift 1 via b[4:0]); SRL → 0x4000_0000.
- EX-to-EX forwarding:
  - Instruction 1: ADD 5+7 gives 12 in MEM.
  - Next instruction: val1_sel=1, val2=1, opcode ADD → alu_res_exe=13.
- WB forwarding and store path:
  - Inputs: wb_result=0xDEAD_BEEF, st_val_sel=2, mem_w_en_id=1.
  - Required: st_val_mem=0xDEAD_BEEF and mem_w_en_mem=1 two edges after the ID inputs are presented.
- Pass-through and FORWARDING_EN off:
  - Control bits, pc_id=0x40 and dest_id=9 appear on pc_mem/dest_mem two edges after being presented.
  - With FORWARDING_EN undefined, val1_sel=1 still yields the ID/EX operand.
